lamp_driver: RTL
================

// Module: lamp_driver
// PURPOSE
//  Registered, parametrised lamp driver for the traffic light controller; replaces the
//  combinational one-hot signal decoder. Per-lamp steady/blink mode from an internal
//  blink prescaler. Latched conflict-fault state forces a fail-safe flashing pattern.
//  Sits between the controller FSM (signal bus) and the lamp output pins.
// PARAMETERS
//  NUM_LAMPS    7           lamps/bits in signal bus (bit0 r_m,1 y_m,2 g_m,3 r_s,4 y_s,5 g_s,6 walk)
//  BLINK_DIV    25000000    clk cycles per blink half-period, >=2
//  CONFLICT_A   7'b0000100  lamp group A (main green)
//  CONFLICT_B   7'b1100000  lamp group B (side green | walk); A and B both lit = conflict
//  FAULT_MASK   7'b0001001  lamps flashed while in fault (both reds)
// PORTS
//  clk          in   1          system clock, all state on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  signal       in   NUM_LAMPS  requested lamps, one bit per lamp
//  blink_en     in   NUM_LAMPS  1 = lamp blinks when requested, 0 = steady
//  clear_fault  in   1          single-cycle pulse, requests exit from fault
//  lamp         out  NUM_LAMPS  registered lamp drive, 1 = on
//  fault        out  1          1 = fault state latched
//  phase        out  1          blink phase, 1 = on half
// BEHAVIOUR
//  Reset (rst_n=0, async): lamp=0, fault=0, phase=1, div counter=0; held while low.
//  Prescaler: counter cnt [$clog2(BLINK_DIV)-1:0] counts 0..BLINK_DIV-1 and wraps;
//   phase toggles on the edge where cnt wraps BLINK_DIV-1 -> 0. Free-running; never
//   stopped by fault or clear_fault. First toggle BLINK_DIV cycles after reset release.
//  conflict (comb) = |(signal & CONFLICT_A) && |(signal & CONFLICT_B).
//  FSM, 2 states, register fault:
//   NORMAL -> FAULT when conflict=1.
//   FAULT  -> NORMAL only when clear_fault=1 and conflict=0 in same cycle.
//   FAULT with clear_fault=1 and conflict=1: stays FAULT (clear ignored, not remembered).
//   fault_next computed combinationally; lamp_next uses fault_next, so a conflicting
//   pattern never reaches lamp, not even for one cycle.
//  Lamp output (registered, 1-cycle latency from signal/blink_en/phase):
//   NORMAL: lamp[i] <= signal[i] & (~blink_en[i] | phase)
//   FAULT : lamp[i] <= FAULT_MASK[i] & phase   (signal, blink_en ignored)
//   phase used for lamp_next is the current registered phase (lamp lags phase by 1 cycle).
//  Exit from fault: cycle after clear is accepted, lamp follows NORMAL rule again.
//  Unused/undefined patterns (e.g. multiple reds, all zero) are passed through as-is;
//   only the A/B conflict is policed.
//  Reset mid-blink or mid-fault: immediately returns to reset values above.
// TESTING  (bench overrides BLINK_DIV=4)
//  1 Reset: rst_n=0 asynchronously mid-cycle with signal=7'h7F -> lamp=0, fault=0, phase=1 at once.
//  2 Steady: signal=7'b0001100, blink_en=0 -> lamp=7'b0001100 one clk later, stable for 20 clk.
//  3 Blink: signal=7'b1001001, blink_en=7'b1000000 -> lamp[6] toggles every 4 clk, lamp[0],[3] steady 1.
//  4 Conflict: signal=7'b0100100 -> fault=1 next edge; lamp never shows 7'b0100100;
//    lamp toggles 7'b0001001/7'b0000000 every 4 clk.
//  5 Clear blocked/accepted: in fault, clear_fault with signal=7'b0100100 -> fault stays 1;
//    then signal=7'b0001100 + clear_fault -> fault=0 and lamp=7'b0001100 one clk later.
//  6 Walk conflict: signal=7'b1000100 -> fault=1; clear_fault same cycle as conflict onset -> fault=1.

Source files
------------

// File: rtl/lamp_driver.sv
// Registered traffic-light lamp driver: per-lamp steady/blink from a free-running
// prescaler, with a latched A/B conflict fault that forces a flashing fail-safe pattern.
module lamp_driver #(
  parameter int                       NUM_LAMPS  = 7,
  parameter int                       BLINK_DIV  = 25000000,
  parameter logic [NUM_LAMPS-1:0]     CONFLICT_A = NUM_LAMPS'(7'b0000100),
  parameter logic [NUM_LAMPS-1:0]     CONFLICT_B = NUM_LAMPS'(7'b1100000),
  parameter logic [NUM_LAMPS-1:0]     FAULT_MASK = NUM_LAMPS'(7'b0001001)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LAMPS-1:0] signal,
  input  logic [NUM_LAMPS-1:0] blink_en,
  input  logic                 clear_fault,
  output logic [NUM_LAMPS-1:0] lamp,
  output logic                 fault,
  output logic                 phase
);

  localparam int               CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FAULT  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic [NUM_LAMPS-1:0] lamp_q, lamp_d;
  logic                 conflict;
  logic                 cnt_wrap;

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    conflict = (|(signal & CONFLICT_A)) && (|(signal & CONFLICT_B));

    state_d = state_q;
    if (state_q == ST_NORMAL) begin
      if (conflict) state_d = ST_FAULT;
    end else begin
      // A clear that arrives while the conflict persists is dropped, not remembered.
      if (clear_fault && !conflict) state_d = ST_NORMAL;
    end

    // Select on the next state so a conflicting request never reaches the pins.
    if (state_d == ST_FAULT) lamp_d = FAULT_MASK & {NUM_LAMPS{phase_q}};
    else                     lamp_d = signal & (~blink_en | {NUM_LAMPS{phase_q}});

    cnt_wrap = (cnt_q == CNT_MAX);
    cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    phase_d  = phase_q ^ cnt_wrap;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      lamp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      lamp_q  <= lamp_d;
    end
  end

  assign lamp  = lamp_q;
  assign fault = (state_q == ST_FAULT);
  assign phase = phase_q;

endmodule
